mem_responder: RTL and testbench
================================

# mem_responder

Behavioural-synthesizable slow main-memory responder answering the 128-bit line-fill/write-back protocol issued by the L1 caches (Icache/Dcache). It sits on the memory side of a cache's mem_* bus, holds a line array, and returns mem_ready after a programmable latency. It replaces the testbench memory model in cache-level and core-level simulations, and its statistics counters let the team measure miss traffic.

## Interface
- LATENCY, 4, BUSY cycles between request acceptance and mem_ready (legal 1..255)
- INDEX_W, 8, line-index bits taken from mem_addr[INDEX_W-1:0]; array depth 2^INDEX_W lines of 128 b

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mem_read  in  1  line read request, level, held until mem_ready observed
- mem_write  in  1  line write request, level, held until mem_ready observed
- mem_addr  in  28  line address; bits above INDEX_W ignored
- mem_wdata  in  128  write line data
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  128  read line data, valid while mem_ready=1, held afterwards
- ld_en  in  1  backdoor preload write enable
- ld_addr  in  INDEX_W  backdoor line index
- ld_data  in  128  backdoor line data
- rd_count  out  16  completed reads, saturating
- wr_count  out  16  completed writes, saturating

## Operation
- States: IDLE, BUSY, READY, RECOVER.
- IDLE: if mem_write or mem_read sampled high -> capture index, wdata, op (write if mem_write=1, else read) into registers; cnt <= LATENCY-1; -> BUSY. Both high: write wins, read dropped.
- BUSY: cnt==0 -> READY; otherwise cnt <= cnt-1. Input changes ignored.
- On the BUSY->READY edge: read: mem_rdata <= array[idx_q]; write: array[idx_q] <= wdata_q. mem_ready registered high for exactly the READY cycle.
- READY -> RECOVER unconditionally; RECOVER -> IDLE unconditionally. Requests seen in READY/RECOVER are ignored (the cache deasserts one cycle after it registers mem_ready).
- rd_count/wr_count increment on the BUSY->READY edge; hold at 16'hFFFF.
- Backdoor: when ld_en=1, array[ld_addr] <= ld_data every edge, in any state. If it collides with a write commit to the same index on the same edge, the protocol write wins.
- A read commit reads the array value before any same-edge backdoor write.

## Timing
- Request sampled at edge E0 -> mem_ready high between E(LATENCY) and E(LATENCY+1). Earliest next acceptance is at edge E(LATENCY+3).
- mem_rdata changes only on a read's BUSY->READY edge; it is otherwise stable, including across writes.
- Reset (rst_n=0, any time, including mid-BUSY/READY): state IDLE, mem_ready=0, mem_rdata=0, cnt=0, rd_count=0, wr_count=0, captured regs 0.
- The line array is not reset. An in-flight write aborted by reset is not committed.
- Contents after a reset mid-write are the pre-request value.
- Outputs are purely registered; no combinational input-to-output path.

## Test plan
- Preload idx 5 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677 via ld_en. Read addr 28'd5 at E0 (LATENCY=4) -> mem_ready=1 only between E4 and E5, mem_rdata equals the preload value and holds it after, rd_count=1.
- Write addr 28'h000_0103 data 128'hDEAD..BEEF (idx 3, upper bits ignored), then read addr 3 -> data returned; wr_count=1, rd_count=1.
- Keep mem_read high through READY and RECOVER (mimicking the cache's one-cycle-late deassert) -> exactly one mem_ready pulse per request; second request accepted only at E7.
- mem_read=mem_write=1 to idx 9 -> write performed, mem_rdata unchanged, wr_count=1, rd_count=0.
- Pull rst_n low during BUSY of a write to idx 2 -> outputs zero immediately (async), array[2] keeps its old value, and the next read works normally.
- Connect the Icache, then run 8 sequential-line instruction fetches, then re-fetch them -> 8 reads total (hits generate none), data matches preload; also run with LATENCY=1 -> mem_ready 1 cycle after acceptance edge.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: slow main-memory line responder for the L1 cache mem_* bus.
// Fixed-latency 128-bit line read/write, backdoor preload port, saturating traffic counters.
module mem_responder #(
   parameter int LATENCY = 4,
   parameter int INDEX_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [27:0]        mem_addr,
   input  logic [127:0]       mem_wdata,
   output logic               mem_ready,
   output logic [127:0]       mem_rdata,
   input  logic               ld_en,
   input  logic [INDEX_W-1:0] ld_addr,
   input  logic [127:0]       ld_data,
   output logic [15:0]        rd_count,
   output logic [15:0]        wr_count
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY    = 2'd1;
   localparam logic [1:0] READY   = 2'd2;
   localparam logic [1:0] RECOVER = 2'd3;

   localparam int         DEPTH    = 1 << INDEX_W;
   localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

   logic [1:0]         state;
   logic [7:0]         cnt;
   logic [INDEX_W-1:0] idx_q;
   logic [127:0]       wdata_q;
   logic               op_write_q;

   logic [127:0]       line_array [DEPTH];

   logic accept;
   logic commit;
   logic commit_write;
   logic commit_read;
   logic ld_blocked;

   assign accept       = (state == IDLE) && (mem_read || mem_write);
   assign commit       = (state == BUSY) && (cnt == 8'd0);
   assign commit_write = commit && op_write_q;
   assign commit_read  = commit && !op_write_q;
   assign ld_blocked   = commit_write && (ld_addr == idx_q);

   // Request capture and the IDLE->BUSY->READY->RECOVER sequence; a write beats a read when both are raised.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         idx_q      <= '0;
         wdata_q    <= '0;
         op_write_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  idx_q      <= mem_addr[INDEX_W-1:0];
                  wdata_q    <= mem_wdata;
                  op_write_q <= mem_write;
                  cnt        <= CNT_INIT;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == 8'd0) begin
                  state <= READY;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            READY:   state <= RECOVER;
            RECOVER: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Completion outputs: ready pulses for the single READY cycle, read data only moves on a read commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_ready <= 1'b0;
         mem_rdata <= '0;
      end else begin
         mem_ready <= commit;
         if (commit_read) begin
            mem_rdata <= line_array[idx_q];
         end
      end
   end

   // Traffic counters stick at all-ones so long runs never wrap back to small values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else begin
         if (commit_read && (rd_count != 16'hFFFF)) begin
            rd_count <= rd_count + 16'd1;
         end
         if (commit_write && (wr_count != 16'hFFFF)) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end

   // Line storage is deliberately not reset; a protocol write beats a backdoor load to the same line.
   always_ff @(posedge clk) begin
      if (commit_write) begin
         line_array[idx_q] <= wdata_q;
      end
      if (ld_en && !ld_blocked) begin
         line_array[ld_addr] <= ld_data;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed checks of mem_responder against a behavioural model.
// A second instance with LATENCY=1 covers the shortest legal latency.
module tb_mem_responder;

   localparam int LAT = 4;
   localparam logic [127:0] PRE5  = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
   localparam logic [127:0] DEAD  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
   localparam logic [127:0] DATA9 = 128'h9999_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [127:0] OLD2  = 128'h2222_2222_AAAA_AAAA_2222_2222_AAAA_AAAA;
   localparam logic [127:0] NEW2  = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
   localparam logic [127:0] PRE7  = 128'h7777_0707_7070_7777_0707_7070_7777_0707;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         mem_read = 1'b0;
   logic         mem_write = 1'b0;
   logic [27:0]  mem_addr = '0;
   logic [127:0] mem_wdata = '0;
   logic         mem_ready;
   logic [127:0] mem_rdata;
   logic         ld_en = 1'b0;
   logic [7:0]   ld_addr = '0;
   logic [127:0] ld_data = '0;
   logic [15:0]  rd_count;
   logic [15:0]  wr_count;

   logic         r1_read = 1'b0;
   logic [27:0]  r1_addr = '0;
   logic         r1_ready;
   logic [127:0] r1_rdata;
   logic         r1_ld_en = 1'b0;
   logic [7:0]   r1_ld_addr = '0;
   logic [127:0] r1_ld_data = '0;
   logic [15:0]  r1_rd_count;
   logic [15:0]  r1_wr_count;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mem_responder #(.LATENCY(LAT), .INDEX_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_count(rd_count), .wr_count(wr_count)
   );

   mem_responder #(.LATENCY(1), .INDEX_W(8)) dut_lat1 (
      .clk(clk), .rst_n(rst_n),
      .mem_read(r1_read), .mem_write(1'b0),
      .mem_addr(r1_addr), .mem_wdata(128'd0),
      .mem_ready(r1_ready), .mem_rdata(r1_rdata),
      .ld_en(r1_ld_en), .ld_addr(r1_ld_addr), .ld_data(r1_ld_data),
      .rd_count(r1_rd_count), .wr_count(r1_wr_count)
   );

   // Behavioural model: a request accepted at edge n completes at edge n+LAT, next acceptance from n+LAT+3.
   logic [127:0] mdl [256];
   logic         m_ready = 1'b0;
   logic [127:0] m_rdata = '0;
   logic [15:0]  m_rd = '0;
   logic [15:0]  m_wr = '0;
   int           n = 0;
   int           acc = -1;
   bit           p_write = 1'b0;
   logic [7:0]   p_idx = '0;
   logic [127:0] p_data = '0;
   bit           wcommit;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready = 1'b0;
         m_rdata = '0;
         m_rd    = '0;
         m_wr    = '0;
         acc     = -1;
      end else begin
         n       = n + 1;
         wcommit = 1'b0;
         m_ready = 1'b0;
         if (acc >= 0 && n == acc + LAT) begin
            m_ready = 1'b1;
            if (p_write) begin
               mdl[p_idx] = p_data;
               wcommit    = 1'b1;
               if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
            end else begin
               m_rdata = mdl[p_idx];
               if (m_rd != 16'hFFFF) m_rd = m_rd + 16'd1;
            end
         end
         if (ld_en && !(wcommit && ld_addr == p_idx)) mdl[ld_addr] = ld_data;
         if ((acc < 0 || n >= acc + LAT + 3) && (mem_read || mem_write)) begin
            acc     = n;
            p_write = mem_write;
            p_idx   = mem_addr[7:0];
            p_data  = mem_wdata;
         end
      end
   end

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_output("cyc_ready", 128'(mem_ready), 128'(m_ready));
         check_output("cyc_rdata", mem_rdata, m_rdata);
         check_output("cyc_rd_count", 128'(rd_count), 128'(m_rd));
         check_output("cyc_wr_count", 128'(wr_count), 128'(m_wr));
      end
   end

   // Cache-like request: hold until mem_ready is seen, then keep it for 'hold' more cycles.
   task automatic apply_stimulus(input bit wr, input bit rd, input logic [27:0] addr,
                                 input logic [127:0] data, input int hold, input bit rand_ld,
                                 output int lat);
      bit seen;
      seen = 1'b0;
      lat  = 0;
      @(negedge clk);
      mem_write = wr;
      mem_read  = rd;
      mem_addr  = addr;
      mem_wdata = data;
      for (int i = 0; i < 300 && !seen; i++) begin
         if (rand_ld) begin
            ld_en   = 1'($urandom);
            ld_addr = 8'($urandom_range(0, 15));
            ld_data = {$urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk);
         lat++;
         if (mem_ready) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("[TB] FAIL ready_timeout: got no pulse, expected mem_ready within 300 cycles");
      end
      ld_en = 1'b0;
      repeat (hold) @(negedge clk);
      mem_write = 1'b0;
      mem_read  = 1'b0;
   endtask

   task automatic idle_gap(input int cycles);
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      int lat;
      int first_seen;
      int second_seen;
      int pulses;

      #1 rst_n = 1'b0;
      chk_en = 1'b1;
      idle_gap(2);
      check_output("reset_ready", 128'(mem_ready), 128'd0);
      check_output("reset_rdata", mem_rdata, 128'd0);
      check_output("reset_rd_count", 128'(rd_count), 128'd0);
      check_output("reset_wr_count", 128'(wr_count), 128'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         ld_en   = 1'b1;
         ld_addr = 8'(i);
         ld_data = (i == 5) ? PRE5 : {$urandom, $urandom, $urandom, $urandom};
         r1_ld_en   = (i == 7);
         r1_ld_addr = 8'(i);
         r1_ld_data = PRE7;
      end
      @(negedge clk);
      ld_en    = 1'b0;
      r1_ld_en = 1'b0;

      idle_gap(3);
      apply_stimulus(1'b0, 1'b1, 28'd5, '0, 1, 1'b0, lat);
      check_output("read5_latency", 128'(lat), 128'(LAT + 1));
      check_output("read5_data", mem_rdata, PRE5);
      check_output("read5_rd_count", 128'(rd_count), 128'd1);
      idle_gap(3);
      check_output("read5_data_held", mem_rdata, PRE5);

      apply_stimulus(1'b1, 1'b0, 28'h000_0103, DEAD, 1, 1'b0, lat);
      check_output("write3_wr_count", 128'(wr_count), 128'd1);
      check_output("write3_rdata_kept", mem_rdata, PRE5);
      idle_gap(3);
      apply_stimulus(1'b0, 1'b1, 28'd3, '0, 1, 1'b0, lat);
      check_output("read3_data", mem_rdata, DEAD);
      check_output("read3_rd_count", 128'(rd_count), 128'd2);

      idle_gap(3);
      apply_stimulus(1'b1, 1'b1, 28'd9, DATA9, 1, 1'b0, lat);
      check_output("both9_rdata_kept", mem_rdata, DEAD);
      check_output("both9_wr_count", 128'(wr_count), 128'd2);
      check_output("both9_rd_count", 128'(rd_count), 128'd2);
      idle_gap(3);
      apply_stimulus(1'b0, 1'b1, 28'd9, '0, 1, 1'b0, lat);
      check_output("read9_data", mem_rdata, DATA9);

      // mem_read held across two full transactions: the second is accepted LAT+3 edges after the first.
      idle_gap(3);
      @(negedge clk);
      mem_read = 1'b1;
      mem_addr = 28'd5;
      first_seen = -1;
      second_seen = -1;
      pulses = 0;
      for (int i = 1; i <= 100 && pulses < 2; i++) begin
         @(negedge clk);
         if (mem_ready) begin
            pulses++;
            if (pulses == 1) first_seen = i;
            else second_seen = i;
         end
      end
      mem_read = 1'b0;
      check_output("held_pulses", 128'(pulses), 128'd2);
      check_output("held_first_latency", 128'(first_seen), 128'(LAT + 1));
      check_output("held_gap", 128'(second_seen - first_seen), 128'(LAT + 3));
      idle_gap(4);
      check_output("held_rd_count", 128'(rd_count), 128'd5);

      // Reset during BUSY of a write must drop the write and clear outputs at once.
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = 8'd2;
      ld_data = OLD2;
      @(negedge clk);
      ld_en = 1'b0;
      idle_gap(2);
      mem_write = 1'b1;
      mem_addr  = 28'd2;
      mem_wdata = NEW2;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      mem_write = 1'b0;
      #1;
      check_output("abort_ready", 128'(mem_ready), 128'd0);
      check_output("abort_rdata", mem_rdata, 128'd0);
      check_output("abort_rd_count", 128'(rd_count), 128'd0);
      check_output("abort_wr_count", 128'(wr_count), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_gap(2);
      apply_stimulus(1'b0, 1'b1, 28'd2, '0, 1, 1'b0, lat);
      check_output("abort_read2_latency", 128'(lat), 128'(LAT + 1));
      check_output("abort_read2_data", mem_rdata, OLD2);
      check_output("abort_read2_rd_count", 128'(rd_count), 128'd1);

      idle_gap(3);
      @(negedge clk);
      r1_read = 1'b1;
      r1_addr = 28'd7;
      lat = -1;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
         @(negedge clk);
         if (r1_ready) lat = i;
      end
      r1_read = 1'b0;
      check_output("lat1_latency", 128'(lat), 128'd2);
      check_output("lat1_data", r1_rdata, PRE7);
      check_output("lat1_rd_count", 128'(r1_rd_count), 128'd1);

      for (int t = 0; t < 150; t++) begin
         int op;
         logic [27:0] addr;
         op   = $urandom_range(0, 2);
         addr = {20'($urandom), 4'h0, 4'($urandom_range(0, 15))};
         apply_stimulus(op != 0, op != 1, addr, {$urandom, $urandom, $urandom, $urandom},
                        $urandom_range(0, 2), 1'b1, lat);
         idle_gap($urandom_range(0, 3));
      end
      idle_gap(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
